// File: rtl/reg_writeback.sv
// In-order write-back buffer merging ALU and mem/mul results onto the single register-file write port.
// Retires one entry per cycle from the head; forwards the youngest pending value for a decode-stage lookup.
module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    aluValid,
  output logic                    aluReady,
  input  logic [4:0]              aluRd,
  input  logic [DATA_WIDTH-1:0]   aluData,
  input  logic                    memValid,
  output logic                    memReady,
  input  logic [4:0]              memRd,
  input  logic [DATA_WIDTH-1:0]   memData,
  output logic                    wrEn,
  output logic [4:0]              rd,
  output logic [DATA_WIDTH-1:0]   dIn,
  input  logic [4:0]              fwdRs,
  output logic                    fwdHit,
  output logic [DATA_WIDTH-1:0]   fwdData,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         alu_slot;
  logic [PW-1:0]         slot;
  logic                  mem_enq;
  logic                  alu_enq;
  logic                  pop;
  logic [4:0]            rd_buf   [DEPTH];
  logic [DATA_WIDTH-1:0] data_buf [DEPTH];

  // memReady keeps one slot in reserve so a same-cycle ALU result always fits.
  assign aluReady = (count <= CW'(DEPTH - 1));
  assign memReady = (count <= CW'(DEPTH - 2));

  assign mem_enq  = memValid && memReady && (memRd != 5'd0);
  assign alu_enq  = aluValid && aluReady && (aluRd != 5'd0);
  assign alu_slot = tail + PW'(mem_enq);

  assign wrEn = (count != '0);
  assign pop  = wrEn;
  assign rd   = wrEn ? rd_buf[head]   : 5'd0;
  assign dIn  = wrEn ? data_buf[head] : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(mem_enq) + PW'(alu_enq);
      count <= count + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);
    end
  end

  // Payload needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      rd_buf[tail]   <= memRd;
      data_buf[tail] <= memData;
    end
    if (alu_enq) begin
      rd_buf[alu_slot]   <= aluRd;
      data_buf[alu_slot] <= aluData;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count) && (fwdRs != 5'd0) && (rd_buf[slot] == fwdRs)) begin
        fwdHit  = 1'b1;
        fwdData = data_buf[slot];
      end
    end
  end

endmodule
